systolic_array_2x2: RTL



---
 rtl/systolic_array_2x2.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/systolic_array_2x2.sv
// 2x2 output-stationary systolic matrix multiplier, C = A x B (unsigned).
// Four MAC processing elements sit in a 2x2 grid. A rows enter from the left
// and B columns enter from the top in a skewed schedule over four cycles.
// Values are forwarded right and down through registers. When the last
// product lands, the accumulators are copied into the held result registers.
// PE index map: 0 = PE11, 1 = PE12, 2 = PE21, 3 = PE22.
module systolic_array_2x2 #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a_11,
    input  logic [DATA_W-1:0] a_12,
    input  logic [DATA_W-1:0] a_21,
    input  logic [DATA_W-1:0] a_22,
    input  logic [DATA_W-1:0] b_11,
    input  logic [DATA_W-1:0] b_12,
    input  logic [DATA_W-1:0] b_21,
    input  logic [DATA_W-1:0] b_22,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  c_11,
    output logic [ACC_W-1:0]  c_12,
    output logic [ACC_W-1:0]  c_21,
    output logic [ACC_W-1:0]  c_22
);

    typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, DONE} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] opA11_q, opA12_q, opA21_q, opA22_q;
    logic [DATA_W-1:0] opB11_q, opB12_q, opB21_q, opB22_q;

    logic [DATA_W-1:0] fwdA11_q, fwdB11_q, fwdA21_q, fwdB12_q;

    logic [ACC_W-1:0]  acc_q   [4];
    logic [ACC_W-1:0]  accNext [4];
    logic [DATA_W-1:0] peA     [4];
    logic [DATA_W-1:0] peB     [4];

    logic [ACC_W-1:0]  c11_q, c12_q, c21_q, c22_q;

    logic accept;
    logic peEnable;

    assign accept   = (state_q == IDLE) && start;
    assign peEnable = (state_q == S1) || (state_q == S2) ||
                      (state_q == S3) || (state_q == S4);

    // State register; an asynchronous reset aborts any run in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Start is only heard in IDLE, so it is dropped while a run is busy or in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = S4;
            S4:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand snapshot taken on the accepting edge so inputs may change mid-run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opA11_q <= '0; opA12_q <= '0; opA21_q <= '0; opA22_q <= '0;
            opB11_q <= '0; opB12_q <= '0; opB21_q <= '0; opB22_q <= '0;
        end else if (accept) begin
            opA11_q <= a_11; opA12_q <= a_12; opA21_q <= a_21; opA22_q <= a_22;
            opB11_q <= b_11; opB12_q <= b_12; opB21_q <= b_21; opB22_q <= b_22;
        end
    end

    // Skewed feed. The forwarded paths stay wired every cycle. They carry zeros whenever their upstream PE had no scheduled operand.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            peA[i] = '0;
            peB[i] = '0;
        end
        peA[1] = fwdA11_q;
        peB[2] = fwdB11_q;
        peA[3] = fwdA21_q;
        peB[3] = fwdB12_q;
        case (state_q)
            S1: begin
                peA[0] = opA11_q;
                peB[0] = opB11_q;
            end
            S2: begin
                peA[0] = opA12_q;
                peB[0] = opB21_q;
                peB[1] = opB12_q;
                peA[2] = opA21_q;
            end
            S3: begin
                peB[1] = opB22_q;
                peA[2] = opA22_q;
            end
            default: begin
            end
        endcase
    end

    // MAC datapath. Each full-width product is zero-extended or truncated to the accumulator width, and the sum wraps.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            accNext[i] = acc_q[i] + ACC_W'({{DATA_W{1'b0}}, peA[i]} * {{DATA_W{1'b0}}, peB[i]});
        end
    end

    // Accumulators and forwarding registers. They are cleared when a run is accepted and step only during S1..S4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
            fwdA11_q <= '0; fwdB11_q <= '0; fwdA21_q <= '0; fwdB12_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
            fwdA11_q <= '0; fwdB11_q <= '0; fwdA21_q <= '0; fwdB12_q <= '0;
        end else if (peEnable) begin
            for (int i = 0; i < 4; i++) acc_q[i] <= accNext[i];
            fwdA11_q <= peA[0];
            fwdB11_q <= peB[0];
            fwdA21_q <= peA[2];
            fwdB12_q <= peB[1];
        end
    end

    // Result registers load on the final feed edge, including that edge's product. They hold their values otherwise so the display can read them at any time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c11_q <= '0; c12_q <= '0; c21_q <= '0; c22_q <= '0;
        end else if (state_q == S4) begin
            c11_q <= accNext[0];
            c12_q <= accNext[1];
            c21_q <= accNext[2];
            c22_q <= accNext[3];
        end
    end

    assign busy = peEnable;
    assign done = (state_q == DONE);
    assign c_11 = c11_q;
    assign c_12 = c12_q;
    assign c_21 = c21_q;
    assign c_22 = c22_q;

endmodule
